// File: rtl/fft_reorder.sv
// +--------------------------------------------------------------------------+
// | fft_reorder: ping-pong frame buffer that turns bit-reversed FFT output   |
// | into natural order. FFT_REORDER_BITREV_EN selects the bit-reversed write |
// | address; undefined, the block is a frame-aligned delay.                  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module fft_reorder #(
  parameter int float_len     = 32,
  parameter int bram_addr_len = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [2*float_len-1:0] data_in,
  input  logic                   data_in_valid,
  output logic [2*float_len-1:0] data_out,
  output logic                   data_out_valid,
  output logic                   data_out_sof
);

  localparam int c_W     = 2 * float_len;
  localparam int c_DEPTH = 1 << bram_addr_len;
  localparam logic [bram_addr_len-1:0] c_LAST = {bram_addr_len{1'b1}};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  logic [c_W-1:0]           mem_q [0:2*c_DEPTH-1];
  logic [bram_addr_len-1:0] wr_cnt_q;
  logic                     wr_bank_q;
  logic                     frame_done_q;
  logic [bram_addr_len-1:0] w_wr_addr;

  state_t                   state_q, state_d;
  logic [bram_addr_len-1:0] rd_cnt_q, rd_cnt_d;
  logic                     rd_bank_q, rd_bank_d;
  logic                     w_rd_en;

  logic [c_W-1:0]           rd_data_q;
  logic                     rd_valid_q;
  logic                     rd_sof_q;
  logic [c_W-1:0]           data_out_q;
  logic                     data_out_valid_q;
  logic                     data_out_sof_q;

`ifdef FFT_REORDER_BITREV_EN
  for (genvar gi = 0; gi < bram_addr_len; gi++) begin : g_bitrev
    assign w_wr_addr[gi] = wr_cnt_q[bram_addr_len-1-gi];
  end
`else
  assign w_wr_addr = wr_cnt_q;
`endif

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (data_in_valid) begin
      mem_q[{wr_bank_q, w_wr_addr}] <= data_in;
    end
    if (w_rd_en) begin
      rd_data_q <= mem_q[{rd_bank_q, rd_cnt_q}];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt_q     <= '0;
      wr_bank_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (data_in_valid) begin
        wr_cnt_q <= wr_cnt_q + 1'b1;
        if (wr_cnt_q == c_LAST) begin
          wr_bank_q    <= ~wr_bank_q;
          frame_done_q <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    w_rd_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_done_q) begin
          state_d   = READ;
          rd_cnt_d  = '0;
          rd_bank_d = ~wr_bank_q;
        end
      end
      READ: begin
        w_rd_en  = 1'b1;
        rd_cnt_d = rd_cnt_q + 1'b1;
        if (rd_cnt_q == c_LAST) begin
          // A frame finishing on our last read chains straight into the other bank.
          if (frame_done_q) begin
            rd_cnt_d  = '0;
            rd_bank_d = ~rd_bank_q;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q       <= 1'b0;
      rd_sof_q         <= 1'b0;
      data_out_q       <= '0;
      data_out_valid_q <= 1'b0;
      data_out_sof_q   <= 1'b0;
    end else begin
      rd_valid_q       <= w_rd_en;
      rd_sof_q         <= w_rd_en && (rd_cnt_q == '0);
      data_out_q       <= rd_valid_q ? rd_data_q : '0;
      data_out_valid_q <= rd_valid_q;
      data_out_sof_q   <= rd_sof_q;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = data_out_valid_q;
  assign data_out_sof   = data_out_sof_q;

endmodule

`default_nettype wire
